// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: shared ALU, single unified memory port, FSM-sequenced.
// Optional instruction-retire trace ports are enabled with `define MCPU_TRACE_EN.
module multi_cycle_cpu #(
   parameter int               ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int               NUM_REGS = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              halted_o,
   output logic [ADDR_W-1:0] pc_o
`ifdef MCPU_TRACE_EN
   ,
   output logic              retire_o,
   output logic [ADDR_W-1:0] retire_pc_o,
   output logic [31:0]       retire_instr_o
`endif
);

   localparam logic [5:0] OP_R    = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23,
                          OP_SW   = 6'h2B, OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_J  = 6'h02;
   localparam logic [5:0] FN_ADD  = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24, FN_OR = 6'h25,
                          FN_SLT  = 6'h2A;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, npc;
   logic [31:0]       ir, a, b, alu_out, mdr;
   logic [31:0]       regs [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wr_idx;
   logic [31:0] simm, alu_res, br_off, npc32, j32, wr_data;
   logic [ADDR_W-1:0] br_tgt, j_tgt;
   logic        legal, is_mem, is_br, is_lw, taken, xfer;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign simm  = {{16{ir[15]}}, ir[15:0]};

   assign is_lw  = (op == OP_LW);
   assign is_mem = is_lw || (op == OP_SW);
   assign is_br  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
   assign xfer   = mem_req_o && mem_ready_i;

   // Index 0 and indices beyond the implemented depth read as zero.
   function automatic logic [31:0] rf_rd(input logic [4:0] idx);
      if (idx == 5'd0 || int'(idx) >= NUM_REGS) return 32'd0;
      return regs[idx];
   endfunction

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_R: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                       (funct == FN_OR)  || (funct == FN_SLT);
         OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = a + simm;
      if (op == OP_R) begin
         case (funct)
            FN_SUB:  alu_res = a - b;
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
            default: alu_res = a + b;
         endcase
      end else if (op == OP_SLTI) begin
         alu_res = {31'd0, $signed(a) < $signed(simm)};
      end
   end

   // Jump target keeps the npc bits above 28 only when the address is wide enough to have them.
   assign taken  = (op == OP_BEQ) ? (a == b) : (a != b);
   assign br_off = simm << 2;
   assign br_tgt = npc + br_off[ADDR_W-1:0];
   assign npc32  = 32'(npc);
   assign j32    = {npc32[31:28], ir[25:0], 2'b00};
   assign j_tgt  = j32[ADDR_W-1:0];

   assign wr_idx  = (op == OP_R) ? rd : rt;
   assign wr_data = is_lw ? mdr : alu_out;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (xfer) state_nxt = S_DECODE;
         S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            if (is_mem)     state_nxt = (alu_res[1:0] == 2'b00) ? S_MEM : S_HALT;
            else if (is_br) state_nxt = S_FETCH;
            else            state_nxt = S_WB;
         end
         S_MEM:    if (xfer) state_nxt = is_lw ? S_WB : S_FETCH;
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc      <= RESET_PC;
         npc     <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: if (xfer) begin
               ir  <= mem_rdata_i;
               npc <= pc + ADDR_W'(4);
            end
            S_DECODE: begin
               a <= rf_rd(rs);
               b <= rf_rd(rt);
            end
            S_EXEC: begin
               alu_out <= alu_res;
               if (op == OP_J)                        pc <= j_tgt;
               else if (op == OP_BEQ || op == OP_BNE) pc <= taken ? br_tgt : npc;
            end
            S_MEM: if (xfer) begin
               if (is_lw) mdr <= mem_rdata_i;
               else       pc  <= npc;
            end
            S_WB: begin
               if (wr_idx != 5'd0 && int'(wr_idx) < NUM_REGS) regs[wr_idx] <= wr_data;
               pc <= npc;
            end
            default: ;
         endcase
      end
   end

   assign mem_req_o   = !rst_i && (state == S_FETCH || state == S_MEM);
   assign mem_we_o    = (state == S_MEM) && !is_lw;
   assign mem_addr_o  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
   assign mem_wdata_o = b;
   assign halted_o    = (state == S_HALT);
   assign pc_o        = pc;

`ifdef MCPU_TRACE_EN
   assign retire_o = !rst_i && ((state == S_WB) || (state == S_EXEC && is_br) ||
                                (state == S_MEM && !is_lw && xfer));
   assign retire_pc_o    = pc;
   assign retire_instr_o = ir;
`endif

   // Bits that are intentionally dropped for narrow address widths or unused encodings.
   logic unused_bits;
   assign unused_bits = ^{ir[10:6], npc32, br_off, alu_out};

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: small programs in a behavioural memory with a
// configurable ready delay; results are observed through stores, PC timing and halt state.
module tb_multi_cycle_cpu;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_req_o, mem_we_o, mem_ready_i, halted_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
`ifdef MCPU_TRACE_EN
   logic        retire_o;
   logic [31:0] retire_pc_o, retire_instr_o;
`endif

   multi_cycle_cpu #(.ADDR_W(32), .RESET_PC(32'h0), .NUM_REGS(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
      .halted_o(halted_o), .pc_o(pc_o)
`ifdef MCPU_TRACE_EN
      , .retire_o(retire_o), .retire_pc_o(retire_pc_o), .retire_instr_o(retire_instr_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural memory: ready rises after 'delay' wait cycles of a held request.
   logic [31:0] mem [256];
   logic [31:0] img [256];
   logic        load_en = 1'b0;
   int          delay = 0;
   int          wcnt  = 0;

   assign mem_rdata_i = mem[mem_addr_o[9:2]];
   assign mem_ready_i = mem_req_o && (wcnt >= delay);

   always @(posedge clk_i) begin
      if (load_en) mem <= img;
      else if (mem_req_o && mem_ready_i && mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
      if (!mem_req_o || mem_ready_i) wcnt <= 0;
      else                           wcnt <= wcnt + 1;
   end

   // Request attributes must hold while a transfer is stalled.
   logic        prev_wait = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;
   always @(negedge clk_i) begin
      if (!rst_i && prev_wait) begin
         chk("hold_req",   {31'd0, mem_req_o}, 32'd1);
         chk("hold_addr",  mem_addr_o, prev_addr);
         chk("hold_we",    {31'd0, mem_we_o}, {31'd0, prev_we});
         chk("hold_wdata", mem_wdata_o, prev_wdata);
      end
      prev_wait  = !rst_i && mem_req_o && !mem_ready_i;
      prev_addr  = mem_addr_o;
      prev_we    = mem_we_o;
      prev_wdata = mem_wdata_o;
   end

`ifdef MCPU_TRACE_EN
   int          r_cnt = 0;
   logic [31:0] r_pc [16];
   always @(negedge clk_i) begin
      if (retire_o) begin
         if (r_cnt < 16) r_pc[r_cnt] = retire_pc_o;
         r_cnt++;
      end
   end
`endif

   task automatic clr_img();
      for (int i = 0; i < 256; i++) img[i] = 32'h0;
   endtask

   task automatic start(input int d);
      delay   = d;
      rst_i   = 1'b1;
      load_en = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      load_en = 1'b0;
      chk("req_in_reset", {31'd0, mem_req_o}, 32'd0);
`ifdef MCPU_TRACE_EN
      r_cnt = 0;
`endif
      rst_i = 1'b0;
      #1;
      chk("rst_req",    {31'd0, mem_req_o}, 32'd1);
      chk("rst_addr",   mem_addr_o, 32'h0);
      chk("rst_halted", {31'd0, halted_o}, 32'd0);
   endtask

   task automatic wait_pc(input logic [31:0] target, input int max, output int n);
      n = 0;
      while (pc_o !== target && n < max) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (pc_o !== target) chk("pc_timeout", pc_o, target);
   endtask

   task automatic wait_halt(input int max, output int n);
      n = 0;
      while (halted_o !== 1'b1 && n < max) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("halted", {31'd0, halted_o}, 32'd1);
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // ALU program, zero-wait memory, results dumped by stores.
      clr_img();
      img[0] = 32'h20010005;  img[1] = 32'h2002FFFD;  img[2] = 32'h00221820;
      img[3] = 32'h0041202A;  img[4] = 32'h00412822;  img[5] = 32'hAC030080;
      img[6] = 32'hAC040084;  img[7] = 32'hAC050088;  img[8] = 32'hFC000000;
      start(0);
      wait_pc(32'h14, 100, n);  chk("alu_5op_cycles", n, 20);
      wait_pc(32'h20, 100, n);  chk("sw_3op_cycles", n, 12);
      wait_halt(20, n);
      chk("add_res", mem[32], 32'd2);
      chk("slt_res", mem[33], 32'd1);
      chk("sub_res", mem[34], 32'hFFFFFFF8);
`ifdef MCPU_TRACE_EN
      chk("retire_cnt", r_cnt, 8);
      for (int i = 0; i < 5; i++) chk("retire_pc", r_pc[i], 32'(i * 4));
`endif

      // Store/load with three wait cycles on every transfer.
      clr_img();
      img[0] = 32'h20030002;  img[1] = 32'hAC030090;  img[2] = 32'h8C060090;
      img[3] = 32'hAC060094;  img[4] = 32'hFC000000;
      img[36] = 32'hDEADBEEF; img[37] = 32'hDEADBEEF;
      start(3);
      wait_pc(32'h4,  100, n);  chk("addi_wait_cycles", n, 7);
      wait_pc(32'h8,  100, n);  chk("sw_wait_cycles", n, 10);
      wait_pc(32'hC,  100, n);  chk("lw_wait_cycles", n, 11);
      wait_pc(32'h10, 100, n);  chk("sw2_wait_cycles", n, 10);
      chk("sw_mem", mem[36], 32'd2);
      chk("lw_mem", mem[37], 32'd2);

      // Branches and jump, then an illegal opcode.
      clr_img();
      img[0]  = 32'h20010007;  img[1]  = 32'h10210002;  img[2]  = 32'h20070001;
      img[3]  = 32'h20070002;  img[4]  = 32'h1400FFFF;  img[5]  = 32'h08000040;
      img[64] = 32'hAC070098;  img[65] = 32'h14200001;  img[66] = 32'hAC01009C;
      img[67] = 32'hAC0100A0;  img[68] = 32'hFC000000;
      img[38] = 32'hDEADBEEF;  img[39] = 32'hDEADBEEF;  img[40] = 32'hDEADBEEF;
      start(0);
      wait_pc(32'h4,   100, n);  chk("addi_cycles", n, 4);
      wait_pc(32'h10,  100, n);  chk("beq_taken", n, 3);
      wait_pc(32'h14,  100, n);  chk("bne_not_taken", n, 3);
      wait_pc(32'h100, 100, n);  chk("j_cycles", n, 3);
      wait_halt(50, n);
      chk("illegal_pc", pc_o, 32'h110);
      chk("halt_req", {31'd0, mem_req_o}, 32'd0);
      repeat (5) @(posedge clk_i);
      #1;
      chk("halt_pc_frozen", pc_o, 32'h110);
      chk("halt_sticky", {31'd0, halted_o}, 32'd1);
      chk("beq_skip", mem[38], 32'd0);
      chk("bne_skip", mem[39], 32'hDEADBEEF);
      chk("bne_target", mem[40], 32'd7);

      // Unaligned load halts from EXEC.
      clr_img();
      img[0] = 32'h8C020006;
      start(0);
      wait_halt(20, n);
      chk("unaligned_cycles", n, 3);
      chk("unaligned_pc", pc_o, 32'h0);
      chk("unaligned_req", {31'd0, mem_req_o}, 32'd0);

      // Restart after halt: registers are clear and $0 ignores writes.
      clr_img();
      img[0] = 32'h20000009;  img[1] = 32'hAC0000A8;  img[2] = 32'hAC0100A4;
      img[3] = 32'hFC000000;
      img[41] = 32'hDEADBEEF; img[42] = 32'hDEADBEEF;
      start(0);
      wait_halt(50, n);
      chk("r0_write_dropped", mem[42], 32'd0);
      chk("reg_cleared", mem[41], 32'd0);
      chk("restart_halt_pc", pc_o, 32'hC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
